// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bus between fetch stage and imem
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with IF/ID register, stall skid and branch redirect
// Optional stall-cycle counter enabled by defining FETCH_PERF_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master imem,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    output logic [31:0]  instr,
    output logic [5:0]   op,
    output logic [5:0]   funct,
    output logic [31:0]  pc_out,
    output logic         valid,
    output logic [31:0]  perf_stall_cnt
);

    typedef enum logic [2:0] {
        S_RST,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] pc_out_nxt;
    logic        valid_nxt;
    logic [31:0] skid, skid_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_RST;
            pc     <= RESET_PC & ~32'h3;
            instr  <= 32'h0;
            pc_out <= 32'h0;
            valid  <= 1'b0;
            skid   <= 32'h0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            instr  <= instr_nxt;
            pc_out <= pc_out_nxt;
            valid  <= valid_nxt;
            skid   <= skid_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        instr_nxt  = instr;
        pc_out_nxt = pc_out;
        valid_nxt  = valid;
        skid_nxt   = skid;

        if (branch_taken && state != S_RST) begin
            // A response arriving alongside the redirect belongs to the old path.
            pc_nxt    = branch_target & ~32'h3;
            instr_nxt = 32'h0;
            valid_nxt = 1'b0;
            skid_nxt  = 32'h0;
            state_nxt = (state == S_WAIT && !imem.imem_ready) ? S_DROP : S_FETCH;
        end else begin
            case (state)
                S_RST: state_nxt = S_FETCH;
                S_FETCH, S_WAIT: begin
                    if (imem.imem_ready) begin
                        if (stall) begin
                            skid_nxt  = imem.imem_rdata;
                            state_nxt = S_HOLD;
                        end else begin
                            instr_nxt  = imem.imem_rdata;
                            pc_out_nxt = pc;
                            valid_nxt  = 1'b1;
                            pc_nxt     = pc + 32'd4;
                            state_nxt  = S_FETCH;
                        end
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        instr_nxt  = skid;
                        pc_out_nxt = pc;
                        valid_nxt  = 1'b1;
                        pc_nxt     = pc + 32'd4;
                        skid_nxt   = 32'h0;
                        state_nxt  = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem.imem_ready) state_nxt = S_FETCH;
                end
                default: state_nxt = S_RST;
            endcase
        end
    end

    assign imem.imem_req  = (state == S_FETCH) || (state == S_WAIT);
    assign imem.imem_addr = pc;
    assign op             = instr[31:26];
    assign funct          = instr[5:0];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= 32'h0;
        end else if (stall && valid && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        ready_drv;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc_out;
    logic        valid;
    logic [31:0] perf_stall_cnt;
    int          nvec = 0;
    int          nmis = 0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus.master),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .instr          (instr),
        .op             (op),
        .funct          (funct),
        .pc_out         (pc_out),
        .valid          (valid),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0020;
            32'h4:   return 32'h1000_0003;
            default: return 32'hA500_0000 ^ a;
        endcase
    endfunction

    assign bus.imem_ready = ready_drv;
    assign bus.imem_rdata = memword(bus.imem_addr);

`ifdef FETCH_PERF_EN
    localparam logic [31:0] PERF5 = 32'd5;
`else
    localparam logic [31:0] PERF5 = 32'd0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ei, input logic [31:0] ep, input logic ev);
        check_eq({tag, ".instr"}, instr, ei);
        check_eq({tag, ".pc_out"}, pc_out, ep);
        check_eq({tag, ".valid"}, {31'b0, valid}, {31'b0, ev});
    endtask

    task automatic check_bus(input string tag, input logic er, input logic [31:0] ea);
        check_eq({tag, ".req"}, {31'b0, bus.imem_req}, {31'b0, er});
        check_eq({tag, ".addr"}, bus.imem_addr, ea);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; ready_drv = 1'b1;
        step(); step();
        check_bus("rst", 1'b0, 32'h0);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        check_eq("rst.perf", perf_stall_cnt, 32'h0);

        rst_n = 1'b1;
        step();
        check_bus("first", 1'b1, 32'h0);
        check_eq("first.valid", {31'b0, valid}, 32'h0);
        step();
        check_ifid("add", 32'h0000_0020, 32'h0, 1'b1);
        check_eq("add.op", {26'b0, op}, 32'h00);
        check_eq("add.funct", {26'b0, funct}, 32'h20);
        check_bus("add", 1'b1, 32'h4);
        step();
        check_ifid("beq", 32'h1000_0003, 32'h4, 1'b1);
        check_eq("beq.op", {26'b0, op}, 32'h04);
        check_eq("beq.funct", {26'b0, funct}, 32'h03);
        check_bus("beq", 1'b1, 32'h8);

        ready_drv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_bus("wait", 1'b1, 32'h8);
            check_ifid("wait", 32'h1000_0003, 32'h4, 1'b1);
        end
        ready_drv = 1'b1;
        step();
        check_ifid("w8", memword(32'h8), 32'h8, 1'b1);
        check_bus("w8", 1'b1, 32'hC);

        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_ifid("hold", memword(32'h8), 32'h8, 1'b1);
            check_bus("hold", 1'b0, 32'hC);
        end
        stall = 1'b0;
        step();
        check_ifid("unstall", memword(32'hC), 32'hC, 1'b1);
        check_bus("unstall", 1'b1, 32'h10);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid("hold2", memword(32'hC), 32'hC, 1'b1);
        end
        check_eq("perf5", perf_stall_cnt, PERF5);
        stall = 1'b0;
        step();
        check_ifid("w10", memword(32'h10), 32'h10, 1'b1);
        check_eq("perf5.after", perf_stall_cnt, PERF5);

        ready_drv = 1'b0;
        step();
        check_bus("wait14", 1'b1, 32'h14);
        branch_taken = 1'b1; branch_target = 32'h0000_0043;
        step();
        branch_taken = 1'b0;
        check_ifid("drop", 32'h0, 32'h10, 1'b0);
        check_eq("drop.op", {26'b0, op}, 32'h0);
        check_eq("drop.funct", {26'b0, funct}, 32'h0);
        check_bus("drop", 1'b0, 32'h40);
        step();
        check_bus("drop2", 1'b0, 32'h40);
        ready_drv = 1'b1;
        step();
        check_ifid("dropend", 32'h0, 32'h10, 1'b0);
        check_bus("dropend", 1'b1, 32'h40);
        step();
        check_ifid("w40", memword(32'h40), 32'h40, 1'b1);

        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        step();
        branch_taken = 1'b0;
        check_ifid("brfetch", 32'h0, 32'h40, 1'b0);
        check_bus("brfetch", 1'b1, 32'hFFFF_FFFC);
        step();
        check_ifid("top", memword(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b1);
        check_bus("wrap", 1'b1, 32'h0);
        step();
        check_ifid("wrap0", 32'h0000_0020, 32'h0, 1'b1);

        ready_drv = 1'b0;
        step();
        check_bus("wait4", 1'b1, 32'h4);
        rst_n = 1'b0;
        #1;
        check_bus("midrst", 1'b0, 32'h0);
        check_ifid("midrst", 32'h0, 32'h0, 1'b0);
        check_eq("midrst.perf", perf_stall_cnt, 32'h0);
        ready_drv = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        check_bus("restart", 1'b1, 32'h0);
        step();
        check_ifid("restart", 32'h0000_0020, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
